// File: rtl/memory_bus_responder.sv
// Bridges an asynchronous-strobe master (rd_n/wr_n) in a decoded address window to a
// level-request/single-cycle-ack memory port, with an ack timeout and a sticky error flag.
module memory_bus_responder #(
    parameter logic [15:0] BASE    = 16'h8000,
    parameter logic [15:0] MASK    = 16'hC000,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [15:0] Addr,
    inout  wire  [15:0] Bus,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic        rdy,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        mem_ack
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        WR_REQ  = 3'd2,
        RD_HOLD = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rd_sync_q, rd_sync_d;
    logic [1:0]  wr_sync_q, wr_sync_d;
    logic        rd_prev_q, rd_prev_d;
    logic        wr_prev_q, wr_prev_d;
    logic [1:0]  warm_q, warm_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic        rdy_q, rdy_d;
    logic        err_q, err_d;
    logic        oe_q, oe_d;

    logic        rd_s, wr_s, sync_ok, rd_fall, wr_fall, conflict, hit, timeout_hit;
    logic [7:0]  cnt_inc;

    assign rd_s        = rd_sync_q[1];
    assign wr_s        = wr_sync_q[1];
    // The synchronizer reset value is not a real sample: a strobe held low across
    // reset release must not look like a fresh falling edge.
    assign sync_ok     = (warm_q == 2'd3);
    assign rd_fall     = sync_ok & rd_prev_q & ~rd_s;
    assign wr_fall     = sync_ok & wr_prev_q & ~wr_s;
    assign conflict    = sync_ok & ~rd_s & ~wr_s;
    assign hit         = ((Addr & MASK) == (BASE & MASK));
    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_d   = state_q;
        rd_sync_d = {rd_sync_q[0], rd_n};
        wr_sync_d = {wr_sync_q[0], wr_n};
        rd_prev_d = rd_s;
        wr_prev_d = wr_s;
        warm_d    = sync_ok ? warm_q : warm_q + 2'd1;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        re_d      = re_q;
        we_d      = we_q;
        err_d     = err_q;
        rdy_d     = (state_q == IDLE) || (state_q == RD_HOLD) || (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (conflict) begin
                    err_d = 1'b1;
                end else if (rd_fall && hit) begin
                    state_d = RD_REQ;
                    addr_d  = Addr;
                    re_d    = 1'b1;
                    cnt_d   = 8'd0;
                end else if (wr_fall && hit) begin
                    state_d = WR_REQ;
                    addr_d  = Addr;
                    wdata_d = Bus;
                    we_d    = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    re_d    = 1'b0;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        rdata_d = 16'hFFFF;
                        re_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = RD_HOLD;
                    end
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    we_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        we_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RD_HOLD: begin
                if (rd_s) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (wr_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        oe_d = (state_d == RD_HOLD);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            rd_sync_q <= 2'b11;
            wr_sync_q <= 2'b11;
            rd_prev_q <= 1'b1;
            wr_prev_q <= 1'b1;
            warm_q    <= 2'd0;
            cnt_q     <= 8'd0;
            rdata_q   <= 16'h0000;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            rdy_q     <= 1'b1;
            err_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_sync_q <= rd_sync_d;
            wr_sync_q <= wr_sync_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
            warm_q    <= warm_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            oe_q      <= oe_d;
        end
    end

    assign Bus       = oe_q ? rdata_q : 16'hzzzz;
    assign rdy       = rdy_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Scenario tasks plus randomized accesses scored against a transaction-level model of
// decode, request length, completion time, timeout data and the sticky error flag.
module tb_memory_bus_responder;

    localparam logic [15:0] BASE = 16'h8000;
    localparam logic [15:0] MASK = 16'hC000;
    localparam int          T    = 15;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] Addr;
    wire  [15:0] Bus;
    logic        rd_n, wr_n;
    logic        rdy, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we, mem_ack;

    logic [15:0] bus_drv;
    logic        bus_drv_en;
    assign Bus = bus_drv_en ? bus_drv : 16'hzzzz;

    int          checks = 0;
    int          passed = 0;
    logic        err_exp;
    logic [15:0] addr_exp;

    always #5 clock = ~clock;

    memory_bus_responder #(.BASE(BASE), .MASK(MASK), .TIMEOUT(T)) dut (
        .clock    (clock),
        .clear    (clear),
        .Addr     (Addr),
        .Bus      (Bus),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .rdy      (rdy),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_ack  (mem_ack)
    );

    // Reference model: behaviour of one access from the master's point of view.
    function automatic bit m_hit(input logic [15:0] a);
        return (a & MASK) == (BASE & MASK);
    endfunction
    function automatic int m_req_cycles(input int d);
        return (d + 1 < T) ? d + 1 : T;
    endfunction
    function automatic bit m_timeout(input int d);
        return d + 1 > T;
    endfunction
    // 2 synchronizer clocks + 1 detect + request cycles + 1 completion edge
    function automatic int m_done(input int n);
        return 3 + n + 1;
    endfunction

    // Tests drive a known zero onto Bus; anything else seen means the DUT is driving too.
    task automatic probe_bus(output logic [15:0] v);
        bus_drv    = 16'h0000;
        bus_drv_en = 1'b1;
        #1;
        v          = Bus;
        bus_drv_en = 1'b0;
        #1;
    endtask

    task automatic release_strobes();
        rd_n       = 1'b1;
        wr_n       = 1'b1;
        bus_drv_en = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    // Starts an access from a sample point and acts as the memory: ack in request cycle d+1.
    task automatic do_access(input bit is_wr, input logic [15:0] a, input logic [15:0] wd,
                             input logic [15:0] rd, input int d, input int limit, input bit stray,
                             output int re_cnt, output int we_cnt, output int done,
                             output bit rdy_always);
        bit fell;
        Addr      = a;
        mem_rdata = rd;
        if (is_wr) begin
            bus_drv    = wd;
            bus_drv_en = 1'b1;
            wr_n       = 1'b0;
        end else begin
            rd_n = 1'b0;
        end
        re_cnt = 0; we_cnt = 0; done = -1; rdy_always = 1'b1; fell = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clock);
            #1;
            mem_ack = 1'b0;
            if (!rdy) begin
                fell       = 1'b1;
                rdy_always = 1'b0;
            end
            if (mem_re) re_cnt++;
            if (mem_we) we_cnt++;
            if (mem_re || mem_we) begin
                if (re_cnt + we_cnt == d + 1) mem_ack = 1'b1;
            end else if (stray && $urandom_range(0, 1) == 1) begin
                mem_ack = 1'b1;
            end
            if (fell && rdy) begin
                done = c;
                break;
            end
        end
        mem_ack = 1'b0;
        if (is_wr) bus_drv_en = 1'b0;
    endtask

    task automatic run_txn(input bit is_wr, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input int d, input bit stray, input string tag);
        int          re_cnt, we_cnt, done, n;
        bit          rdy_always, hit, tout;
        logic [15:0] v, exp_rd;
        hit    = m_hit(a);
        n      = hit ? m_req_cycles(d) : 0;
        tout   = hit && m_timeout(d);
        exp_rd = tout ? 16'hFFFF : rd;
        do_access(is_wr, a, wd, rd, d, hit ? 40 : 8, stray, re_cnt, we_cnt, done, rdy_always);
        if (hit) begin
            err_exp  = err_exp | tout;
            addr_exp = a;
            checks++;
            if (re_cnt !== (is_wr ? 0 : n)) $display("FAIL %s mem_re cycles: got %0d expected %0d", tag, re_cnt, is_wr ? 0 : n);
            else passed++;
            checks++;
            if (we_cnt !== (is_wr ? n : 0)) $display("FAIL %s mem_we cycles: got %0d expected %0d", tag, we_cnt, is_wr ? n : 0);
            else passed++;
            checks++;
            if (done !== m_done(n)) $display("FAIL %s rdy completion clock: got %0d expected %0d", tag, done, m_done(n));
            else passed++;
            checks++;
            if (mem_addr !== a) $display("FAIL %s mem_addr: got %h expected %h", tag, mem_addr, a);
            else passed++;
            checks++;
            if (err !== err_exp) $display("FAIL %s err: got %b expected %b", tag, err, err_exp);
            else passed++;
            if (is_wr) begin
                checks++;
                if (mem_wdata !== wd) $display("FAIL %s mem_wdata: got %h expected %h", tag, mem_wdata, wd);
                else passed++;
                release_strobes();
                checks++;
                if (rdy !== 1'b1 || mem_we !== 1'b0) $display("FAIL %s idle after wr_n rise: got rdy=%b mem_we=%b expected rdy=1 mem_we=0", tag, rdy, mem_we);
                else passed++;
            end else begin
                checks++;
                if (Bus !== exp_rd) $display("FAIL %s Bus at completion: got %h expected %h", tag, Bus, exp_rd);
                else passed++;
                rd_n = 1'b1;
                repeat (2) @(posedge clock);
                #1;
                checks++;
                if (Bus !== exp_rd) $display("FAIL %s Bus while sync rd_n low: got %h expected %h", tag, Bus, exp_rd);
                else passed++;
                @(posedge clock);
                #1;
                probe_bus(v);
                checks++;
                if (v !== 16'h0000) $display("FAIL %s Bus after rd_n rise: got %h expected released", tag, v);
                else passed++;
                release_strobes();
            end
        end else begin
            checks++;
            if (re_cnt + we_cnt !== 0) $display("FAIL %s miss strobes: got %0d expected 0", tag, re_cnt + we_cnt);
            else passed++;
            checks++;
            if (rdy_always !== 1'b1) $display("FAIL %s miss rdy: got dropped expected steady 1", tag);
            else passed++;
            checks++;
            if (mem_addr !== addr_exp) $display("FAIL %s miss mem_addr: got %h expected %h", tag, mem_addr, addr_exp);
            else passed++;
            probe_bus(v);
            checks++;
            if (v !== 16'h0000) $display("FAIL %s miss Bus: got %h expected released", tag, v);
            else passed++;
            release_strobes();
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        clear = 1'b1; rd_n = 1'b1; wr_n = 1'b1; mem_ack = 1'b0;
        Addr = 16'h0000; mem_rdata = 16'h0000; bus_drv = 16'h0000; bus_drv_en = 1'b0;
        err_exp = 1'b0; addr_exp = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (rdy !== 1'b1 || err !== 1'b0) $display("FAIL reset rdy/err: got %b/%b expected 1/0", rdy, err);
        else passed++;
        checks++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset strobes: got %b/%b expected 0/0", mem_re, mem_we);
        else passed++;
        checks++;
        if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) $display("FAIL reset mem_addr/mem_wdata: got %h/%h expected 0000/0000", mem_addr, mem_wdata);
        else passed++;
        probe_bus(v);
        checks++;
        if (v !== 16'h0000) $display("FAIL reset Bus: got %h expected released", v);
        else passed++;
        clear = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (rdy !== 1'b1) $display("FAIL post-reset rdy: got %b expected 1", rdy);
        else passed++;
    endtask

    task automatic test_read_hit();
        run_txn(1'b0, 16'h8123, 16'h0000, 16'hBEEF, 1, 1'b0, "read_hit");
    endtask

    task automatic test_write_hit();
        run_txn(1'b1, 16'h8004, 16'h1234, 16'h0000, 0, 1'b0, "write_hit");
    endtask

    task automatic test_miss();
        run_txn(1'b0, 16'h4000, 16'h0000, 16'h5555, 0, 1'b1, "miss");
    endtask

    task automatic test_ack_at_limit();
        run_txn(1'b0, 16'hBFFE, 16'h0000, 16'h0F0F, T - 1, 1'b0, "ack_at_limit");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 16'h8123, 16'h0000, 16'h1357, 1000, 1'b0, "timeout");
    endtask

    task automatic test_conflict();
        int          strobes;
        bit          rdy_all;
        logic [15:0] v;
        Addr = 16'h8000; strobes = 0; rdy_all = 1'b1;
        rd_n = 1'b0; wr_n = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            if (mem_re || mem_we) strobes++;
            if (!rdy) rdy_all = 1'b0;
        end
        err_exp = 1'b1;
        checks++;
        if (strobes !== 0) $display("FAIL conflict strobes: got %0d expected 0", strobes);
        else passed++;
        checks++;
        if (rdy_all !== 1'b1) $display("FAIL conflict rdy: got dropped expected steady 1");
        else passed++;
        checks++;
        if (err !== 1'b1) $display("FAIL conflict err: got %b expected 1", err);
        else passed++;
        probe_bus(v);
        checks++;
        if (v !== 16'h0000) $display("FAIL conflict Bus: got %h expected released", v);
        else passed++;
        release_strobes();
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        int strobes;
        bit rdy_all;
        Addr = 16'h8123; mem_rdata = 16'hAAAA; seen = 1'b0;
        rd_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (mem_re) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) $display("FAIL reset_mid_read request: got no mem_re expected mem_re within 10 clocks");
        else passed++;
        clear = 1'b1;
        #1;
        checks++;
        if (mem_re !== 1'b0 || rdy !== 1'b1) $display("FAIL reset_mid_read abort: got mem_re=%b rdy=%b expected 0/1", mem_re, rdy);
        else passed++;
        checks++;
        if (err !== 1'b0 || mem_addr !== 16'h0000) $display("FAIL reset_mid_read clear: got err=%b mem_addr=%h expected 0/0000", err, mem_addr);
        else passed++;
        err_exp = 1'b0; addr_exp = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        strobes = 0; rdy_all = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (mem_re || mem_we) strobes++;
            if (!rdy) rdy_all = 1'b0;
        end
        checks++;
        if (strobes !== 0 || rdy_all !== 1'b1) $display("FAIL reset_mid_read held strobe: got %0d strobe clocks rdy_steady=%b expected 0/1", strobes, rdy_all);
        else passed++;
        release_strobes();
    endtask

    task automatic test_random();
        bit          is_wr;
        logic [15:0] a;
        int          d;
        for (int i = 0; i < 24; i++) begin
            is_wr = 1'($urandom_range(0, 1));
            a     = 16'($urandom);
            if ($urandom_range(0, 2) != 0) a[15:14] = 2'b10;
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 1, T + 1))
                                            : int'($urandom_range(0, 3));
            run_txn(is_wr, a, 16'($urandom), 16'($urandom), d, 1'b1, "random");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_miss();
        test_ack_at_limit();
        test_conflict();
        test_reset_mid_read();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/memory_bus_responder.md
MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

Interface
REQ-001 Parameter BASE, default 16'h8000: match value for address decode.
REQ-002 Parameter MASK, default 16'hC000: bits of Addr compared against BASE.
REQ-003 Parameter TIMEOUT, default 15: cycles to wait for mem_ack before aborting; range 1..255.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 clear  input  1  reset, asynchronous, active-high.
REQ-006 Addr  input  16  address bus, driven by the master's address registers.
REQ-007 Bus  inout  16  transfer bus; sampled on writes, driven on reads, else High-Z.
REQ-008 rd_n  input  1  master read strobe, active low, asynchronous to clock.
REQ-009 wr_n  input  1  master write strobe, active low, asynchronous to clock.
REQ-010 rdy  output  1  high when idle or when the current access has completed.
REQ-011 err  output  1  sticky error flag (timeout or rd_n/wr_n conflict).
REQ-012 mem_addr  output  16  latched address to memory.
REQ-013 mem_wdata  output  16  latched write data to memory.
REQ-014 mem_rdata  input  16  read data from memory, valid with mem_ack.
REQ-015 mem_re, mem_we  output  1 each  memory request strobes, level, held until ack or abort.
REQ-016 mem_ack  input  1  single-cycle memory completion.

Function
REQ-017 rd_n and wr_n SHALL each pass through a 2-flop synchronizer; a falling edge is detected from synchronized history 2'b10 (previous high, current low).
REQ-018 Hit SHALL be ((Addr & MASK) == (BASE & MASK)), evaluated in the cycle the edge is detected.
REQ-019 FSM states: IDLE, RD_REQ, WR_REQ, RD_HOLD, DONE.
REQ-020 IDLE: rdy=1; read edge with hit -> RD_REQ; write edge with hit -> WR_REQ; miss -> stay IDLE, no memory strobe, Bus stays High-Z.
REQ-021 On entering RD_REQ/WR_REQ, mem_addr SHALL latch Addr; WR_REQ also latches Bus into mem_wdata in the same cycle; rdy SHALL drop in the following cycle.
REQ-022 RD_REQ: mem_re=1 until mem_ack; on ack, capture mem_rdata into the read register -> RD_HOLD.
REQ-023 RD_HOLD: drive read register onto Bus while synchronized rd_n is low; rdy=1; on synchronized rd_n high -> IDLE, Bus High-Z next cycle.
REQ-024 WR_REQ: mem_we=1 until mem_ack -> DONE.
REQ-025 DONE: rdy=1; wait for synchronized wr_n high -> IDLE.
REQ-026 Latency: an access reaching memory with zero-wait ack SHALL complete (rdy high) 5 clocks after the raw strobe falling edge (2 synchronizer + 1 detect + 1 request + 1 ack).
REQ-027 Timeout counter (8-bit) SHALL clear on entering RD_REQ/WR_REQ and increment each cycle without ack; reaching TIMEOUT SHALL drop mem_re/mem_we, set err, and go to RD_HOLD (read register = 16'hFFFF) or DONE.
REQ-028 Both synchronized strobes low in the same cycle in IDLE SHALL be ignored and SHALL set err.
REQ-029 New strobe edges during a non-IDLE state SHALL be ignored; no queueing.
REQ-030 mem_ack when neither mem_re nor mem_we is asserted SHALL be ignored.
REQ-031 Bus SHALL never be driven outside RD_HOLD; Addr is never driven.
REQ-032 err SHALL clear only on clear.

Reset
REQ-033 clear asserted SHALL immediately force: state IDLE, rdy=1, err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, read register=0, counter=0, synchronizers=2'b11, Bus High-Z.
REQ-034 clear mid-access SHALL abort without completing the memory transaction; after release, a strobe still held low produces no edge and no access.

Verification
REQ-035 Read hit: Addr=16'h8123, rd_n falls, mem_ack after 2 cycles with mem_rdata=16'hBEEF -> mem_re for 2 cycles, Bus=16'hBEEF while rd_n low, High-Z after rd_n rises.
REQ-036 Write hit: Addr=16'h8004, Bus=16'h1234, wr_n falls, ack immediately -> mem_addr=16'h8004, mem_wdata=16'h1234, one-cycle mem_we, rdy low then high.
REQ-037 Miss: Addr=16'h4000, rd_n falls -> no mem_re, rdy stays 1, Bus High-Z.
REQ-038 Timeout: read hit, mem_ack never -> mem_re high TIMEOUT cycles then low, err=1, Bus=16'hFFFF while rd_n low.
REQ-039 Conflict: rd_n and wr_n fall together -> no memory strobe, err=1, state IDLE.
REQ-040 Reset mid-read: clear during RD_REQ -> mem_re=0 same cycle, rdy=1; rd_n held low across release -> no new access.
